// File: rtl/finalsoc_nios2_gen2_0_cpu_ocimem_responder.sv
// System-clock responder for debug OCI memory commands: address load, read, write, auto-increment.
// Optional shared CPU slave port on the debug RAM is enabled by defining OCIMEM_CPU_PORT_EN.
module finalsoc_nios2_gen2_0_cpu_ocimem_responder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
`ifdef OCIMEM_CPU_PORT_EN
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
`endif
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_RDC  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic              err_q, err_d;
  logic              inc_q, inc_d;
  logic              ready_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic              jdo_addr_ok;
  logic              take_any;
  logic              take_multi;
  logic [ADDR_W-1:0] mon_a_inc;

  logic              jtag_stall;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jdo_addr    = jdo[9+ADDR_W-1:9];
  assign jdo_addr_ok = ({1'b0, jdo_addr} < DEPTH_L);
  assign take_any    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign take_multi  = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
  assign mon_a_inc   = (mon_a_q == LAST_ADDR) ? '0 : mon_a_q + ADDR_W'(1);

`ifdef OCIMEM_CPU_PORT_EN
  logic cpu_grant;

  // The CPU owns the RAM on any request except while JTAG is capturing read data.
  assign cpu_grant       = (cpu_read | cpu_write) && (state_q != ST_RDC);
  assign jtag_stall      = cpu_grant && ((state_q == ST_RD) || (state_q == ST_WR));
  assign ram_addr        = cpu_grant ? cpu_address : mon_a_q;
  assign ram_we          = reset_n && (cpu_grant ? cpu_write : (state_q == ST_WR));
  assign ram_be          = cpu_grant ? cpu_byteenable : 4'hF;
  assign ram_wdata       = cpu_grant ? cpu_writedata : mon_d_q;
  assign cpu_readdata    = ram_rdata;
  assign cpu_waitrequest = (state_q == ST_RDC);
`else
  assign jtag_stall = 1'b0;
  assign ram_addr   = mon_a_q;
  assign ram_we     = reset_n && (state_q == ST_WR);
  assign ram_be     = 4'hF;
  assign ram_wdata  = mon_d_q;
`endif

  // One byte-wide RAM per lane so byte enables map onto plain block-RAM writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (ram_we && ram_be[gi]) begin
          mem_q[ram_addr] <= ram_wdata[gi*8 +: 8];
        end
        rd_q <= mem_q[ram_addr];
      end

      assign ram_rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mon_d_d = mon_d_q;
    mon_a_d = mon_a_q;
    err_d   = err_q;
    inc_d   = inc_q;

    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          if (jdo_addr_ok) begin
            mon_a_d = jdo_addr;
            if (jdo[35]) begin
              err_d = 1'b0;
            end
            if (jdo[34]) begin
              state_d = ST_RD;
              inc_d   = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          mon_d_d = jdo[34:3];
          state_d = ST_WR;
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD;
          inc_d   = 1'b1;
        end
        // Placed after the clear so a simultaneous set wins.
        if (take_multi) begin
          err_d = 1'b1;
        end
      end
      ST_RD: begin
        if (!jtag_stall) begin
          state_d = ST_RDC;
        end
      end
      ST_RDC: begin
        mon_d_d = ram_rdata;
        if (inc_q) begin
          mon_a_d = mon_a_inc;
        end
        state_d = ST_IDLE;
      end
      ST_WR: begin
        if (!jtag_stall) begin
          mon_a_d = mon_a_inc;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && take_any) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mon_d_q <= '0;
      mon_a_q <= '0;
      err_q   <= 1'b0;
      inc_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mon_d_q <= mon_d_d;
      mon_a_q <= mon_a_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_finalsoc_nios2_gen2_0_cpu_ocimem_responder.sv
// Randomized scoreboard bench for the OCI memory responder: a behavioural model predicts
// each command's completion; a monitor compares whenever the responder finishes an op.
module tb_finalsoc_nios2_gen2_0_cpu_ocimem_responder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;
`ifdef OCIMEM_CPU_PORT_EN
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
`endif

  always #5 clk = ~clk;

  finalsoc_nios2_gen2_0_cpu_ocimem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
`ifdef OCIMEM_CPU_PORT_EN
    .cpu_address            (cpu_address),
    .cpu_read               (cpu_read),
    .cpu_write              (cpu_write),
    .cpu_writedata          (cpu_writedata),
    .cpu_byteenable         (cpu_byteenable),
    .cpu_readdata           (cpu_readdata),
    .cpu_waitrequest        (cpu_waitrequest),
`endif
    .MonDReg                (MonDReg),
    .MonAReg                (MonAReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
    int          low;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_addr;
  logic [31:0] m_data;
  logic        m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Apply one command issued while idle; returns the completion it should produce.
  task automatic model_op(input bit a, input bit b, input bit n, input logic [37:0] j, output exp_t e);
    int ad;
    int winners;
    winners = int'(a) + int'(b) + int'(n);
    e.low = 0;
    if (a) begin
      ad = int'(j[16:9]);
      if (ad >= DEPTH) begin
        m_err = 1'b1;
      end else begin
        m_addr = ad;
        if (j[35]) m_err = 1'b0;
        if (j[34]) begin
          m_data = m_mem[ad];
          e.low = 2;
        end
      end
    end else if (b) begin
      m_data = j[34:3];
      m_mem[m_addr] = m_data;
      m_addr = (m_addr + 1) % DEPTH;
      e.low = 1;
    end else if (n) begin
      m_data = m_mem[m_addr];
      m_addr = (m_addr + 1) % DEPTH;
      e.low = 2;
    end
    if (winners > 1) m_err = 1'b1;
    e.data = m_data;
    e.addr = 32'(m_addr);
    e.err  = m_err;
  endtask

  function automatic logic [37:0] j_rand();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  function automatic logic [37:0] j_load(input int ad, input bit rd, input bit clr);
    logic [37:0] j;
    j = j_rand();
    j[16:9] = 8'(ad);
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] j_write(input logic [31:0] d);
    logic [37:0] j;
    j = j_rand();
    j[34:3] = d;
    return j;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (monitor_ready === 1'b1) return;
      @(negedge clk);
    end
    check("idle_timeout", 64'(monitor_ready), 64'd1);
  endtask

  task automatic issue(input bit a, input bit b, input bit n, input logic [37:0] j);
    exp_t e;
    model_op(a, b, n, j, e);
    exp_q.push_back(e);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = n;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    wait_idle();
  endtask

  // Monitor: an op completes when ready rises, or on the edge an immediate command is taken.
  initial begin
    int low;
    exp_t e;
    low = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n !== 1'b1) begin
        low = 0;
      end else if (monitor_ready === 1'b1) begin
        if (low > 0 || take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) begin
          n_txn++;
          $display("txn %0d: MonDReg=%08h MonAReg=%0d err=%0b ready_low=%0d",
                   n_txn, MonDReg, MonAReg, monitor_error, low);
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("MonDReg", 64'(MonDReg), 64'(e.data));
            check("MonAReg", 64'(MonAReg), 64'(e.addr));
            check("monitor_error", 64'(monitor_error), 64'(e.err));
            check("ready_low_cycles", 64'(low), 64'(e.low));
          end
        end
        low = 0;
      end else begin
        low++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [37:0] j;
    int sel;
    bit a, b, n;
    int saved;

    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
`ifdef OCIMEM_CPU_PORT_EN
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = 4'h0;
`endif
    m_addr = 0;
    m_data = '0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_MonDReg", 64'(MonDReg), 64'd0);
    check("reset_MonAReg", 64'(MonAReg), 64'd0);
    check("reset_ready", 64'(monitor_ready), 64'd1);
    check("reset_error", 64'(monitor_error), 64'd0);

    // Fill every word so the model knows all RAM contents; the address wraps back to 0.
    issue(1, 0, 0, j_load(0, 0, 0));
    for (int i = 0; i < DEPTH; i++) issue(0, 1, 0, j_write($urandom()));

    issue(1, 0, 0, j_load(16, 0, 0));
    issue(0, 1, 0, j_write(32'hDEADBEEF));
    issue(1, 0, 0, j_load(16, 1, 0));

    issue(1, 0, 0, j_load(0, 0, 0));
    for (int i = 1; i <= 4; i++) issue(0, 1, 0, j_write(32'(i)));
    issue(1, 0, 0, j_load(0, 0, 0));
    for (int i = 0; i < 4; i++) issue(0, 0, 1, j_rand());
    issue(1, 0, 0, j_load(DEPTH - 1, 0, 0));
    issue(0, 0, 1, j_rand());

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: issue(1, 0, 0, j_load(int'($urandom_range(0, DEPTH - 1)), 0, 1'($urandom())));
        1: issue(1, 0, 0, j_load(int'($urandom_range(0, DEPTH - 1)), 1, 1'($urandom())));
        2: issue(0, 1, 0, j_write($urandom()));
        3: issue(0, 0, 1, j_rand());
        4: issue(1, 0, 0, j_load(int'($urandom_range(DEPTH, 255)), 1'($urandom()), 1'($urandom())));
        default: begin
          do begin
            a = 1'($urandom()); b = 1'($urandom()); n = 1'($urandom());
          end while (int'(a) + int'(b) + int'(n) < 2);
          j = a ? j_load(int'($urandom_range(0, DEPTH - 1)), 1'($urandom()), 1'($urandom()))
                : j_write($urandom());
          issue(a, b, n, j);
        end
      endcase
    end

    // Write pulse on the cycle after a read starts: dropped, error set, read unaffected.
    issue(1, 0, 0, j_load(40, 0, 1));
    saved = m_addr;
    model_op(0, 0, 1, j_rand(), e);
    m_err = 1'b1;
    e.err = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1;
    jdo = j_write(~m_mem[saved]);
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    wait_idle();
    issue(1, 0, 0, j_load(saved, 1, 0));
    issue(1, 0, 0, j_load(saved + 1, 1, 0));
    issue(1, 0, 0, j_load(3, 0, 1));

    // Address load and write in the same cycle: load wins, MonDReg keeps its value.
    issue(1, 1, 0, j_load(32, 0, 0));

    // Reset on the write cycle aborts the write.
    issue(1, 0, 0, j_load(5, 0, 0));
    @(negedge clk);
    jdo = j_write(~m_mem[5]);
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_addr = 0;
    m_data = '0;
    m_err = 1'b0;
    check("wr_reset_ready", 64'(monitor_ready), 64'd1);
    check("wr_reset_MonAReg", 64'(MonAReg), 64'd0);
    issue(1, 0, 0, j_load(5, 1, 0));

`ifdef OCIMEM_CPU_PORT_EN
    // CPU write colliding with a JTAG read: CPU lands, JTAG read finishes one cycle late.
    j = j_load(7, 1, 0);
    model_op(1, 0, 0, j, e);
    e.low = 3;
    exp_q.push_back(e);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    cpu_write = 1'b1;
    cpu_address = 8'd9;
    cpu_writedata = $urandom();
    cpu_byteenable = 4'hF;
    m_mem[9] = cpu_writedata;
    @(negedge clk);
    cpu_write = 1'b0;
    wait_idle();
    issue(1, 0, 0, j_load(9, 1, 0));
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
